// File: rtl/chacha_block_assembler_if.sv
// rtl/chacha_block_assembler_if.sv - symbol-in / block-out handshake bundle for the block assembler
interface chacha_block_assembler_if #(
  parameter int DATA_SIZE   = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_W       = $clog2(BLOCK_BYTES + 1)
);
  logic [DATA_SIZE-1:0]             in_data;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  logic                             flush;
  logic [BLOCK_BYTES*DATA_SIZE-1:0] out_block;
  logic [LEN_W-1:0]                 out_len;
  logic                             out_valid;
  logic                             out_ready;
  logic                             full;
  logic                             empty;

  modport master (
    output in_data, in_valid, in_last, flush, out_ready,
    input  in_ready, out_block, out_len, out_valid, full, empty
  );

  modport slave (
    input  in_data, in_valid, in_last, flush, out_ready,
    output in_ready, out_block, out_len, out_valid, full, empty
  );
endinterface

// File: rtl/chacha_block_assembler.sv
// rtl/chacha_block_assembler.sv - collects serialiser symbols into ping-pong keystream blocks
module chacha_block_assembler #(
  parameter int DATA_SIZE   = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_BANKS   = 2,
  parameter int LEN_W       = $clog2(BLOCK_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  chacha_block_assembler_if.slave  bus
);

  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W = $clog2(NUM_BANKS + 1);
  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_BANKS);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BLOCK_BYTES);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_CLOSED  = 2'd2
  } bank_state_t;

  bank_state_t          bank_state_q [NUM_BANKS];
  bank_state_t          bank_state_d [NUM_BANKS];
  logic [DATA_SIZE-1:0] mem_q        [NUM_BANKS][BLOCK_BYTES];
  logic [LEN_W-1:0]     len_q        [NUM_BANKS];
  logic [PTR_W-1:0]     wp_q;
  logic [PTR_W-1:0]     rp_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [LEN_W-1:0]     widx_q;

  logic                 ready;
  logic                 accept;
  logic                 close;
  logic                 pop;
  logic [LEN_W-1:0]     widx_inc;
  logic [LEN_W-1:0]     close_len;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready comes only from registered occupancy, so out_ready never reaches in_ready combinationally.
  assign ready    = !rst && (cnt_q != CNT_MAX);
  assign accept   = bus.in_valid && ready;
  assign widx_inc = widx_q + LEN_W'(1);

  // A flush with nothing written is a no-op; a flush alongside an accepted symbol includes it.
  assign close     = ready && ((accept && (bus.in_last || (widx_inc == LEN_FULL)))
                               || (bus.flush && (accept || (widx_q != '0))));
  assign close_len = accept ? widx_inc : widx_q;
  assign pop       = bus.out_valid && bus.out_ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = (bank_state_q[rp_q] == BANK_CLOSED);
  assign bus.out_len   = len_q[rp_q];
  assign bus.full      = (cnt_q == CNT_MAX);
  assign bus.empty     = (cnt_q == '0) && (widx_q == '0);

  // Flatten the read bank onto the wide output; unused positions are already zero.
  always_comb begin
    bus.out_block = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      bus.out_block[i*DATA_SIZE +: DATA_SIZE] = mem_q[rp_q][i];
    end
  end

  // Per-bank lifecycle: EMPTY -> FILLING -> CLOSED -> EMPTY.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_state_d[b] = bank_state_q[b];
      if (wp_q == PTR_W'(b)) begin
        if (close) begin
          bank_state_d[b] = BANK_CLOSED;
        end else if (accept) begin
          bank_state_d[b] = BANK_FILLING;
        end
      end
      if (pop && (rp_q == PTR_W'(b))) begin
        bank_state_d[b] = BANK_EMPTY;
      end
    end
  end

  // Bank state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_q[b] <= BANK_EMPTY;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_q[b] <= bank_state_d[b];
      end
    end
  end

  // Symbol storage, pointers and closed-bank count; a drained bank is zeroed so partial blocks pad with 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      widx_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        len_q[b] <= '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      if (accept) begin
        mem_q[wp_q][widx_q[IDX_W-1:0]] <= bus.in_data;
      end

      if (close) begin
        len_q[wp_q] <= close_len;
        widx_q      <= '0;
        wp_q        <= ptr_next(wp_q);
      end else if (accept) begin
        widx_q <= widx_inc;
      end

      // The write bank is never the read bank while a block is presented, so these never collide.
      if (pop) begin
        rp_q        <= ptr_next(rp_q);
        len_q[rp_q] <= '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          mem_q[rp_q][i] <= '0;
        end
      end

      case ({close, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_assembler.sv
// tb/tb_chacha_block_assembler.sv - self-checking bench for chacha_block_assembler
module tb_chacha_block_assembler;

  localparam int DS = 8;
  localparam int BB = 64;
  localparam int NB = 2;
  localparam int LW = $clog2(BB + 1);

  typedef struct {
    logic [BB*DS-1:0] data;
    int               len;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  blk_t       pend[$];
  logic [7:0] part[$];

  chacha_block_assembler_if #(.DATA_SIZE(DS), .BLOCK_BYTES(BB), .LEN_W(LW)) bus ();

  chacha_block_assembler #(
    .DATA_SIZE(DS), .BLOCK_BYTES(BB), .NUM_BANKS(NB), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic blk_t mk_blk();
    blk_t b;
    b.data = '0;
    b.len  = part.size();
    for (int i = 0; i < part.size(); i++) b.data[i*DS +: DS] = part[i];
    return b;
  endfunction

  task automatic check_outputs(input bit m_ready);
    chk("in_ready",  512'(bus.in_ready),  512'(m_ready));
    chk("out_valid", 512'(bus.out_valid), 512'(pend.size() > 0));
    chk("full",      512'(bus.full),      512'(pend.size() == NB));
    chk("empty",     512'(bus.empty),     512'((pend.size() == 0) && (part.size() == 0)));
    if (pend.size() > 0) begin
      chk("out_len",   512'(bus.out_len),   512'(pend[0].len));
      chk("out_block", 512'(bus.out_block), 512'(pend[0].data));
    end
  endtask

  // One clock: drive, check against the model, then advance the model across the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic f, input logic r);
    bit m_ready;
    bit m_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.flush     = f;
    bus.out_ready = r;
    #2;
    m_ready = (pend.size() < NB);
    m_pop   = (pend.size() > 0) && r;
    check_outputs(m_ready);
    @(posedge clk);
    if (m_ready) begin
      if (v) part.push_back(d);
      if ((v && (part.size() == BB || l)) || (f && part.size() > 0)) begin
        pend.push_back(mk_blk());
        part.delete();
      end
    end
    if (m_pop) void'(pend.pop_front());
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("in_ready_during_rst", 512'(bus.in_ready), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    part.delete();
    #1;
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_out_len",   512'(bus.out_len),   512'(0));
    chk("rst_out_block", 512'(bus.out_block), 512'(0));
    chk("rst_full",      512'(bus.full),      512'(0));
    chk("rst_empty",     512'(bus.empty),     512'(1));
    chk("rst_in_ready",  512'(bus.in_ready),  512'(1));
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Counting block 0x00..0x3F.
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    drain();

    // Two blocks of identical symbols, back to back.
    for (int i = 0; i < 128; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    drain();

    // Short block closed by in_last, then a fresh block.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 + i), 1'(i == 4), 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    drain();

    // Back-pressure: both banks fill, one handshake frees one bank.
    do_reset();
    for (int i = 0; i < 130; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    drain();

    // Flush with nothing written, then flush alongside the third symbol.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
    drain();

    // Randomised traffic with last, flush and back-pressure.
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset with one closed block and a partial block pending.
    for (int i = 0; i < 104; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chacha_block_assembler.md
# chacha_block_assembler

Parametrised successor to the serialiser-side byte collector. It gathers DATA_SIZE-bit symbols from the ChaCha20 serialiser into BLOCK_BYTES-symbol blocks, using NUM_BANKS ping-pong banks with explicit valid/ready handshakes on both sides. It also supports partial blocks (last/flush with zero padding) and a length tag. It sits between the state-matrix serialiser and the keystream XOR / Poly1305 message stage.

## Interface
- DATA_SIZE, 8: symbol width in bits.
- BLOCK_BYTES, 64: symbols per block (one serialised 4x4 state matrix); must be ≥2.
- NUM_BANKS, 2: number of block buffers; must be ≥1.
- LEN_W, $clog2(BLOCK_BYTES+1): width of the length tag.

- clk  in  1  sole clock; all logic updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_SIZE  input symbol.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  qualifies in_valid; this symbol closes the current block.
- in_ready  out  1  block accepts a symbol this cycle.
- flush  in  1  close the current partial block without a new symbol.
- out_block  out  BLOCK_BYTES*DATA_SIZE  symbol i at bits [i*DATA_SIZE +: DATA_SIZE].
- out_len  out  LEN_W  number of valid symbols in out_block (1..BLOCK_BYTES).
- out_valid  out  1  a closed block is presented.
- out_ready  in  1  consumer takes the block when out_valid && out_ready.
- full  out  1  all banks closed and waiting (equals !in_ready outside reset).
- empty  out  1  no bank closed and write bank holds 0 symbols.

## Operation
- Per-bank state: EMPTY -> FILLING (first symbol written) -> CLOSED (BLOCK_BYTES-th symbol, in_last, or flush) -> EMPTY (output handshake).
- Write pointer wp and read pointer rp index banks. Both wrap from NUM_BANKS-1 to 0. A closed-bank count cnt is held in the range 0..NUM_BANKS.
- A symbol is accepted when in_valid && in_ready. It is written at write index widx of bank wp, and widx then increments. Accepted symbols are never dropped or duplicated; equal consecutive values are stored normally.
- A bank closes when one of the following holds:
  - the accepted symbol makes widx == BLOCK_BYTES;
  - the accepted symbol carries in_last;
  - flush is high while widx > 0.
- On close, the bank's length is latched to widx, widx resets to 0, wp advances and cnt increments.
- flush with widx == 0 is ignored. flush in the same cycle as an accepted symbol closes the bank including that symbol.
- Unused symbol positions of a partial block read as 0. The bank is zero-cleared on entry to EMPTY, or equivalently masked on output by out_len.
- Output: out_valid = (cnt > 0). out_block and out_len come from bank rp. On out_valid && out_ready, rp advances and cnt decrements.
- Close and output handshake in the same cycle: cnt is unchanged. Both pointers advance.
- in_ready = !rst && (cnt < NUM_BANKS). It depends only on registered state, with no combinational path from out_ready.
- While out_valid is high and out_ready is low, out_block and out_len stay stable.

## Timing
- Reset values: cnt=0, wp=rp=0, widx=0, all banks cleared. Outputs: out_valid=0, out_len=0, out_block=0, full=0, empty=1. in_ready=0 while rst is high, and 1 in the first cycle after.
- Reset mid-operation discards every partial and closed block. No output handshake completes in a reset cycle.
- Latency: a closing symbol accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Throughput with NUM_BANKS ≥ 2 and out_ready held high: one symbol per cycle sustained, with no bubbles.
- With NUM_BANKS = 1: in_ready drops for at least one cycle per block, from close until the handshake edge.
- Back-pressure: when cnt == NUM_BANKS, in_ready=0 and in_valid is ignored, including in_last and flush. An output handshake in that cycle raises in_ready the next cycle.

## Test plan
- Reset, then 64 accepted symbols 0x00..0x3F with out_ready=1 -> one block, out_len=64, symbol i = i, out_valid asserted exactly one cycle after the 64th accept.
- 128 symbols all 0xAA, out_ready=1 -> two blocks, each 64×0xAA. No symbol is lost or merged.
- 5 symbols 0x11..0x15, last one with in_last -> out_len=5, symbols 5..63 = 0. Next block starts at widx 0.
- out_ready=0, NUM_BANKS=2, 130 offered symbols -> in_ready falls after the 128th accept and full=1. After one handshake, in_ready=1 on the next cycle and accepted symbol 129 starts bank 0.
- flush with widx=0 -> no block produced. flush together with the 3rd accepted symbol -> out_len=3.
- rst asserted after 40 symbols with one closed block pending -> out_valid=0, empty=1 next cycle. A fresh 64-symbol block then emerges uncorrupted.
